// File: rtl/spi_ser_pkg.sv
// Shared definitions for the SPI frame serializer: width helpers and FSM encoding.
// SPI_SER_PARITY_EN widens the frame by one trailing even-parity bit.
package spi_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ABORT = 2'd2
  } ser_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int frame_w(input int opw, input int addrw);
`ifdef SPI_SER_PARITY_EN
    return 2 + opw + addrw;
`else
    return 1 + opw + addrw;
`endif
  endfunction

endpackage

// File: rtl/spi_ser_fifo.sv
// Small power-of-two request FIFO; a push while full is refused even if a pop
// happens in the same cycle.
module spi_ser_fifo
  import spi_ser_pkg::*;
#(
  parameter int W     = 25,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_frame_serializer.sv
// SPI-slave transmit serializer: queues {opcode, addr} requests and shifts
// {start, opcode, addr[, parity]} frames out on miso. Optional: SPI_SER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a shift edge with cs active and a queued request
// SHIFT | frame in flight, one bit per shift edge
// ABORT | cs dropped mid-frame; one clk to report err, then IDLE
module spi_frame_serializer
  import spi_ser_pkg::*;
#(
  parameter int ADDRW     = 23,
  parameter int OPW       = 2,
  parameter int DEPTH     = 2,
  parameter int SHIFT_NEG = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             n_cs,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [OPW-1:0]   opcode,
  input  logic [ADDRW-1:0] addr,
  output logic             miso,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int FRAME_W = frame_w(OPW, ADDRW);
  localparam int CNTW    = clog2(FRAME_W + 1);
  localparam int DW      = OPW + ADDRW;

  logic [1:0]         spi_sync;
  logic [1:0]         ncs_sync;
  logic               spi_prev;
  logic               shift_edge;
  logic               ncs_last;
  logic               cs_act;
  logic               full;
  logic               empty;
  logic               start;
  logic [DW-1:0]      head;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_sh;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_sh;
  logic               first_bit;
  logic               next_bit;
  logic [CNTW-1:0]    cnt;
  ser_state_t         state;

  assign ready_out = !full;
  assign start     = (state == IDLE) && shift_edge && cs_act && !empty;

  spi_ser_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (valid_in),
    .push_data ({opcode, addr}),
    .pop       (start),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sync <= 2'b11;
      ncs_sync <= 2'b11;
      spi_prev <= 1'b1;
    end else begin
      spi_sync <= {spi_sync[0], spi_clk};
      ncs_sync <= {ncs_sync[0], n_cs};
      spi_prev <= spi_sync[1];
    end
  end

  assign shift_edge = (SHIFT_NEG != 0) ? (spi_prev && !spi_sync[1])
                                       : (!spi_prev && spi_sync[1]);

  // Chip select only counts once it has been stable across two shift edges,
  // which filters glitches shorter than an SPI period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_last <= 1'b1;
      cs_act   <= 1'b0;
    end else if (shift_edge) begin
      ncs_last <= ncs_sync[1];
      if (ncs_sync[1] == ncs_last) cs_act <= !ncs_sync[1];
    end
  end

`ifdef SPI_SER_PARITY_EN
  assign frame = {1'b1, head, ^{1'b1, head}};
`else
  assign frame = {1'b1, head};
`endif

  always_comb begin
    first_bit = frame[0];
    next_bit  = sr[0];
    frame_sh  = frame >> 1;
    sr_sh     = sr >> 1;
    if (MSB_FIRST != 0) begin
      first_bit = frame[FRAME_W-1];
      next_bit  = sr[FRAME_W-1];
      frame_sh  = frame << 1;
      sr_sh     = sr << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      miso  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= frame_sh;
            miso  <= first_bit;
            cnt   <= CNTW'(FRAME_W - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (shift_edge) begin
            miso <= 1'b0;
          end
        end
        SHIFT: begin
          // cs loss wins over a coincident shift edge
          if (!cs_act) begin
            state <= ABORT;
            err   <= 1'b1;
            miso  <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (shift_edge) begin
            miso <= next_bit;
            sr   <= sr_sh;
            cnt  <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_serializer.sv
// Bench for spi_frame_serializer: dut0 uses the default shift settings, dut1 is
// LSB-first on rising edges; both are checked against a bit-queue frame model.
`timescale 1ns/1ps
module tb_spi_frame_serializer;

  localparam int ADDRW = 23;
  localparam int OPW   = 2;
  localparam int DEPTH = 2;
  localparam int DW    = OPW + ADDRW;
`ifdef SPI_SER_PARITY_EN
  localparam int FW = DW + 2;
`else
  localparam int FW = DW + 1;
`endif
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sclk = 2'b01;
  logic [1:0] ncs = 2'b11;
  logic [1:0] vld = 2'b00;
  logic [1:0][OPW-1:0] op = '0;
  logic [1:0][ADDRW-1:0] ad = '0;
  logic [1:0] rdy, miso, busy, done, err;

  int errors = 0;
  int checks = 0;
  int done_seen[2];
  int err_seen[2];
  int exp_done[2];
  int exp_err[2];
  bit act[2];
  bit prev_smp[2];
  bit restore[2];
  logic [DW-1:0] mq[2][$];
  bit eb[2][$];

  always #5 clk = ~clk;

  spi_frame_serializer #(.ADDRW(ADDRW), .OPW(OPW), .DEPTH(DEPTH), .SHIFT_NEG(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk[0]), .n_cs(ncs[0]), .valid_in(vld[0]),
    .ready_out(rdy[0]), .opcode(op[0]), .addr(ad[0]), .miso(miso[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]));

  spi_frame_serializer #(.ADDRW(ADDRW), .OPW(OPW), .DEPTH(DEPTH), .SHIFT_NEG(0), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk[1]), .n_cs(ncs[1]), .valid_in(vld[1]),
    .ready_out(rdy[1]), .opcode(op[1]), .addr(ad[1]), .miso(miso[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]));

  // Accepted requests enter the model queue.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rst_n && vld[d] && rdy[d]) mq[d].push_back({op[d], ad[d]});
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) done_seen[d]++;
      if (err[d]) err_seen[d]++;
    end
  end

  task automatic load_frame(input int d);
    logic [DW-1:0] e;
    logic [FW-1:0] f;
    e = mq[d].pop_front();
`ifdef SPI_SER_PARITY_EN
    f = {1'b1, e, 1'b0};
    f[0] = (($countones(e) + 1) % 2) == 1;
`else
    f = {1'b1, e};
`endif
    if (d == 0) for (int i = FW - 1; i >= 0; i--) eb[d].push_back(f[i]);
    else        for (int i = 0; i < FW; i++) eb[d].push_back(f[i]);
  endtask

  // One SPI period: drive edge, model step, check, opposite edge.
  task automatic spi_cycle(input int d, input bit glitch);
    bit old_act, e_miso, e_busy;
    sclk[d] = (d == 0) ? 1'b0 : 1'b1;
    old_act = act[d];
    if (ncs[d] == prev_smp[d]) act[d] = !ncs[d];
    prev_smp[d] = ncs[d];
    if (eb[d].size() == 0 && old_act && mq[d].size() > 0) load_frame(d);
    e_miso = 1'b0;
    e_busy = 1'b0;
    if (eb[d].size() > 0) begin
      e_miso = eb[d].pop_front();
      e_busy = eb[d].size() > 0;
      if (!e_busy) exp_done[d]++;
      else if (!act[d]) begin
        e_miso = 1'b0;
        e_busy = 1'b0;
        exp_err[d]++;
        eb[d].delete();
      end
    end
    if (restore[d]) begin
      #(HALF / 2) ncs[d] = 1'b0;
      restore[d] = 1'b0;
      #(HALF / 2);
    end else #(HALF);
    checks += 2;
    if (miso[d] !== e_miso) begin
      errors++;
      $display("FAIL miso_bit dut%0d t=%0t got %b required %b", d, $time, miso[d], e_miso);
    end
    if (busy[d] !== e_busy) begin
      errors++;
      $display("FAIL busy dut%0d t=%0t got %b required %b", d, $time, busy[d], e_busy);
    end
    sclk[d] = ~sclk[d];
    if (glitch) begin
      #(HALF / 2) ncs[d] = 1'b1;
      restore[d] = 1'b1;
      #(HALF / 2);
    end else #(HALF);
  endtask

  task automatic run(input int d, input int n);
    for (int i = 0; i < n; i++) spi_cycle(d, 1'b0);
  endtask

  task automatic set_cs(input int d, input logic v);
    ncs[d] = v;
    #(HALF);
  endtask

  task automatic push(input int d, input logic [OPW-1:0] o, input logic [ADDRW-1:0] a);
    int n;
    n = 0;
    @(negedge clk);
    vld[d] = 1'b1; op[d] = o; ad[d] = a;
    @(posedge clk);
    while (!rdy[d] && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL push_timeout dut%0d ready_out=%b required 1", d, rdy[d]);
    end
    @(negedge clk);
    vld[d] = 1'b0;
  endtask

  task automatic check_counts(input string name, input int d);
    checks += 2;
    if (done_seen[d] !== exp_done[d]) begin
      errors++;
      $display("FAIL %s_done dut%0d pulses=%0d required %0d", name, d, done_seen[d], exp_done[d]);
    end
    if (err_seen[d] !== exp_err[d]) begin
      errors++;
      $display("FAIL %s_err dut%0d pulses=%0d required %0d", name, d, err_seen[d], exp_err[d]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b required 1", d, rdy[d]); end
      if (miso[d] !== 1'b0) begin errors++; $display("FAIL reset_miso dut%0d got %b required 0", d, miso[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b required 0", d, busy[d]); end
      if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got %b required 0", d, done[d]); end
      if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b required 0", d, err[d]); end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    set_cs(0, 1'b0);
    run(0, 2);
    push(0, 2'b10, 23'h155555);
    run(0, FW + 2);
    for (int i = 0; i < 3; i++) begin
      push(0, OPW'($urandom), ADDRW'($urandom));
      run(0, FW + 1);
    end
    check_counts("single", 0);
  endtask

  task automatic test_back_to_back();
    push(0, OPW'($urandom), ADDRW'($urandom));
    push(0, OPW'($urandom), ADDRW'($urandom));
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_full ready_out=%b required 0", rdy[0]); end
    fork
      push(0, OPW'($urandom), ADDRW'($urandom));
      run(0, 3 * FW + 2);
    join
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_drain ready_out=%b required 1", rdy[0]); end
    check_counts("b2b", 0);
  endtask

  task automatic test_abort();
    push(0, OPW'($urandom), ADDRW'($urandom));
    push(0, OPW'($urandom), ADDRW'($urandom));
    run(0, 10);
    set_cs(0, 1'b1);
    run(0, 3);
    set_cs(0, 1'b0);
    run(0, FW + 4);
    check_counts("abort", 0);
  endtask

  task automatic test_cs_glitch();
    push(0, OPW'($urandom), ADDRW'($urandom));
    run(0, 8);
    spi_cycle(0, 1'b1);
    run(0, FW);
    check_counts("glitch", 0);
  endtask

  task automatic test_lsb_rise();
    set_cs(1, 1'b0);
    run(1, 2);
    push(1, 2'b00, 23'h000001);
    run(1, FW + 1);
    push(1, OPW'($urandom), ADDRW'($urandom));
    run(1, FW + 1);
    check_counts("lsb_rise", 1);
  endtask

  task automatic test_reset_mid_frame();
    push(0, 2'b01, 23'h000000);
    run(0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (miso[0] !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b required 0", miso[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b required 1", rdy[0]); end
    if (done[0] !== 1'b0 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pulse done=%b err=%b required 0 0", done[0], err[0]);
    end
    for (int d = 0; d < 2; d++) begin
      eb[d].delete();
      mq[d].delete();
      act[d] = 1'b0;
      prev_smp[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_counts("midrst", 0);
    run(0, 2);
    push(0, 2'b01, 23'h000000);
    run(0, FW + 1);
    check_counts("post_rst", 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_seen[d] = 0; err_seen[d] = 0; exp_done[d] = 0; exp_err[d] = 0;
      act[d] = 1'b0; prev_smp[d] = 1'b1; restore[d] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_cs_glitch();
    test_lsb_rise();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
